resampler_in: RTL and testbench
===============================

Name: resampler_in

Overview:
- Front-end framer for the compression pipeline. Captures one full sample frame (40 x 512-bit blocks) and streams it block by block into the DCT stage.
- Each block transfer uses a valid/ready handshake.
- Inverse of the output resampler, which packs DCT results back into a frame.
- Block k occupies frame bits [512*k +: 512]; block 0 is the LSBs.

Parameters:
- BLOCK_W, 512, width of one DCT block in bits
- NUM_BLOCKS, 40, blocks per frame
- FRAME_W, BLOCK_W*NUM_BLOCKS (20480), frame width; derived, not overridden
- IDX_W, 6, width of block index; must satisfy 2**IDX_W >= NUM_BLOCKS

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, synchronous, active-high
- en  input  1  global clock enable; when low, all state and outputs hold
- start  input  1  request to capture sample_in and begin streaming; honoured only in IDLE
- sample_in  input  FRAME_W  frame to be split; sampled only on an accepted start
- block_out  output  BLOCK_W  current block data; 0 when block_valid is low
- block_valid  output  1  block_out/block_idx valid
- block_ready  input  1  DCT stage accepts the block
- block_idx  output  IDX_W  index 0..NUM_BLOCKS-1 of the block on block_out
- busy  output  1  high in LOAD/STREAM
- done  output  1  one-cycle pulse after the last block is accepted

Behaviour:
- Reset: synchronous, active-high, takes priority over en. Effects:
  - state=IDLE, block_valid=0, block_idx=0, busy=0, done=0.
  - block_out reads 0 because it is gated by valid.
  - Frame register is not reset.
- en=0: no state, counter, frame register or output changes. A handshake with block_ready=1 during en=0 is not a transfer.
- States:
  - IDLE: busy=0, block_valid=0. start=1 (with en=1) latches sample_in into frame_reg, sets block_idx=0, goes to LOAD.
  - LOAD: one cycle; busy=1, block_valid=0. Goes to STREAM. This gives registered block_out timing after capture.
  - STREAM: block_valid=1, busy=1. block_out = frame_reg[BLOCK_W*block_idx +: BLOCK_W], driven from a registered mux output.
    - Transfer = en & block_valid & block_ready.
    - On transfer with block_idx < NUM_BLOCKS-1: block_idx increments, next block is presented the following cycle, and valid stays high (no bubble).
    - On transfer with block_idx == NUM_BLOCKS-1: goes to DONE, block_valid drops next cycle, block_idx resets to 0.
  - DONE: one cycle; done=1, busy=0, block_valid=0. Returns to IDLE.
- Latency: start accepted in cycle N → block 0 valid in cycle N+2. With block_ready held high, block 39 is accepted in cycle N+41 and done=1 in cycle N+42.
- Valid/data stability: while block_valid=1 and no transfer occurs, block_out and block_idx remain stable. block_ready may toggle freely; valid never drops before a transfer.
- start outside IDLE: ignored, including start coincident with the DONE cycle. The frame is not re-latched. A new frame needs start in IDLE, at the earliest the cycle after done.
- sample_in may change any time after the capture edge without affecting the stream.
- Reset mid-STREAM: next cycle is IDLE with valid=0. Remaining blocks are discarded and no done pulse is produced.
- Index arithmetic: block offset = block_idx * BLOCK_W, full-width multiply (no 511 stride). block_idx never exceeds NUM_BLOCKS-1.

Decomposition:
- Shared package resampler_pkg holds:
  - BLOCK_W, NUM_BLOCKS, FRAME_W, IDX_W constants, shared with resampler_out.
  - State encoding enum: IDLE=2'd0, LOAD=2'd1, STREAM=2'd2, DONE=2'd3.
- One natural sub-module: block_mux. It is a registered FRAME_W→BLOCK_W slice selector with index input and enable, reused for the block_out path.

Test Plan:
- Basic stream: block k of sample_in = {16{32'(k+1)}}, start for 1 cycle, block_ready=1 → 40 consecutive beats with block_idx 0..39 and block_out matching {16{k+1}}; done=1 exactly once, 42 cycles after start; busy low afterward.
- Backpressure: block_ready pattern 1,0,0,1,... random with 50% duty → each block_out held stable while ready=0; all 40 blocks received in order exactly once; no duplicate or skipped idx.
- Enable stall: drop en for 5 cycles mid-stream at block_idx=17 with ready=1 → no transfer, idx stays 17, outputs frozen; stream resumes at 17 when en returns.
- Start ignored while busy: pulse start with a different sample_in (all 32'hDEADBEEF) at idx=10 and on the done cycle → original frame data continues; no restart; next start in IDLE captures the new frame.
- Reset mid-operation: assert rst at idx=25 → next cycle valid=0, busy=0, done=0, idx=0; no done pulse; a fresh start streams the full 40 blocks from idx 0.
- Back-to-back frames: start in the cycle after done with frame B → frame B block 0 valid 2 cycles later; frame A/B data never interleave.

Source files
------------

// File: rtl/resampler_pkg.sv
// rtl/resampler_pkg.sv - shared frame/block constants and state encoding for the resamplers
package resampler_pkg;

    localparam int BLOCK_W    = 512;
    localparam int NUM_BLOCKS = 40;
    localparam int FRAME_W    = BLOCK_W * NUM_BLOCKS;
    localparam int IDX_W      = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/block_mux.sv
// rtl/block_mux.sv - registered frame-to-block slice selector
module block_mux #(
    parameter int BLOCK_W    = 512,
    parameter int NUM_BLOCKS = 40,
    parameter int IDX_W      = 6
) (
    input  logic                          clk,
    input  logic                          en,
    input  logic [IDX_W-1:0]              sel,
    input  logic [BLOCK_W*NUM_BLOCKS-1:0] frame,
    output logic [BLOCK_W-1:0]            block
);

    // No reset: the consumer gates this register with its valid flag.
    always_ff @(posedge clk) begin
        if (en) begin
            block <= frame[BLOCK_W*int'(sel) +: BLOCK_W];
        end
    end

endmodule

// File: rtl/resampler_in.sv
// rtl/resampler_in.sv - captures a sample frame and streams it block by block
module resampler_in
    import resampler_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start,
    input  logic [FRAME_W-1:0] sample_in,
    output logic [BLOCK_W-1:0] block_out,
    output logic               block_valid,
    input  logic               block_ready,
    output logic [IDX_W-1:0]   block_idx,
    output logic               busy,
    output logic               done
);

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_inc;
    logic [FRAME_W-1:0] frame_reg;
    logic [BLOCK_W-1:0] mux_q;
    logic [IDX_W-1:0]   mux_sel;
    logic               mux_en;
    logic               xfer;
    logic               last;
    logic               accept_start;

    assign idx_inc      = idx_q + IDX_W'(1);
    assign last         = (idx_q == IDX_W'(NUM_BLOCKS - 1));
    assign xfer         = en & block_valid & block_ready;
    assign accept_start = en & start & (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else if (en) begin
            state_q <= state_d;
            if (accept_start) begin
                idx_q <= '0;
            end else if (xfer) begin
                idx_q <= last ? '0 : idx_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept_start) begin
            frame_reg <= sample_in;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = STREAM;
            STREAM:  if (block_ready && last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q == LOAD) || (state_q == STREAM);
        block_valid = (state_q == STREAM);
        done        = (state_q == DONE);
    end

    // LOAD primes block 0; each non-final transfer preloads the next block so valid never bubbles.
    assign mux_sel = (state_q == LOAD) ? '0 : idx_inc;
    assign mux_en  = en & ~rst & ((state_q == LOAD) | (xfer & ~last));

    block_mux #(
        .BLOCK_W    (BLOCK_W),
        .NUM_BLOCKS (NUM_BLOCKS),
        .IDX_W      (IDX_W)
    ) u_block_mux (
        .clk   (clk),
        .en    (mux_en),
        .sel   (mux_sel),
        .frame (frame_reg),
        .block (mux_q)
    );

    assign block_out = block_valid ? mux_q : '0;
    assign block_idx = idx_q;

endmodule

// File: tb/tb_resampler_in.sv
// tb/tb_resampler_in.sv - directed self-checking bench for resampler_in
module tb_resampler_in;
    import resampler_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               start;
    logic [FRAME_W-1:0] sample_in;
    logic [BLOCK_W-1:0] block_out;
    logic               block_valid;
    logic               block_ready;
    logic [IDX_W-1:0]   block_idx;
    logic               busy;
    logic               done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    resampler_in dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .start       (start),
        .sample_in   (sample_in),
        .block_out   (block_out),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .block_idx   (block_idx),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [BLOCK_W-1:0] got, input logic [BLOCK_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BLOCK_W-1:0] exp_blk(input int pat, input int k);
        logic [31:0] w;
        case (pat)
            0:       w = 32'(k + 1);
            1:       w = 32'hDEADBEEF;
            default: w = 32'hB000_0000 + 32'(k);
        endcase
        return {16{w}};
    endfunction

    function automatic logic [FRAME_W-1:0] make_frame(input int pat);
        logic [FRAME_W-1:0] f;
        for (int k = 0; k < NUM_BLOCKS; k++) f[BLOCK_W*k +: BLOCK_W] = exp_blk(pat, k);
        return f;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready high; 1: random ready; 2: en stall at idx 17; 3: stray starts at idx 10 and on done
    task automatic receive(input int pat, input int mode);
        int k = 0;
        int cnt = 0;
        int guard = 0;
        bit stalled = 0;
        bit poked = 0;
        sample_in = make_frame(pat);
        start = 1'b1;
        step; cnt++;
        start = 1'b0;
        check("load_busy", busy, 1);
        check("load_valid", block_valid, 0);
        step; cnt++;
        while (k < NUM_BLOCKS && guard < 2000) begin
            guard++;
            if (mode == 2 && k == 17 && !stalled) begin
                stalled = 1;
                block_ready = 1'b1;
                en = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    step; cnt++;
                    check("stall_idx", block_idx, 17);
                    check("stall_valid", block_valid, 1);
                    check("stall_data", block_out, exp_blk(pat, 17));
                end
                en = 1'b1;
            end
            block_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            check("valid", block_valid, 1);
            check("idx", block_idx, k);
            check("data", block_out, exp_blk(pat, k));
            check("busy", busy, 1);
            check("no_done", done, 0);
            if (mode == 3 && k == 10 && !poked) begin
                poked = 1;
                start = 1'b1;
                sample_in = make_frame(1);
            end
            step; cnt++;
            start = 1'b0;
            if (block_ready) k++;
        end
        if (guard >= 2000) check("timeout", 1, 0);
        block_ready = 1'b0;
        check("done", done, 1);
        check("done_busy", busy, 0);
        check("done_valid", block_valid, 0);
        check("done_idx", block_idx, 0);
        if (mode == 0) check("latency", cnt, 42);
        if (mode == 3) begin
            start = 1'b1;
            sample_in = make_frame(1);
        end
        step;
        start = 1'b0;
        check("done_once", done, 0);
        check("idle_busy", busy, 0);
        check("idle_valid", block_valid, 0);
        check("idle_out", block_out, 0);
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b1;
        start = 1'b0;
        block_ready = 1'b0;
        sample_in = '0;
        step;
        step;
        rst = 1'b0;
        check("rst_valid", block_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_idx", block_idx, 0);
        check("rst_out", block_out, 0);

        receive(0, 0);
        receive(2, 0);
        receive(0, 1);
        receive(2, 2);
        receive(0, 3);
        receive(1, 0);

        sample_in = make_frame(2);
        start = 1'b1;
        step;
        start = 1'b0;
        step;
        block_ready = 1'b1;
        for (int k = 0; k < 25; k++) step;
        check("pre_rst_idx", block_idx, 25);
        rst = 1'b1;
        step;
        rst = 1'b0;
        block_ready = 1'b0;
        check("mid_rst_valid", block_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_idx", block_idx, 0);
        check("mid_rst_out", block_out, 0);
        for (int s = 0; s < 3; s++) begin
            step;
            check("mid_rst_nodone", done, 0);
        end
        receive(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
